// File: rtl/jtag_master_seq_if.sv
// Command/response handshake bundle for jtag_master_seq.
// The master modport belongs to the command issuer and the slave modport to the sequencer.
interface jtag_master_seq_if #(
  parameter int DATA_W = 64
) ();
  localparam int LEN_W = $clog2(DATA_W) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_master_seq.sv
// JTAG TAP command sequencer: TAP reset, IR scan and DR scan, with an automatic TAP reset while the TAP state is unknown.
// Optional JTAG_MASTER_SEQ_TCK_DIV_EN adds tck_div to stretch each jtag_tck phase to tck_div+1 cycles.
//
// state     | meaning
// IDLE      | waiting for a command, jtag_tck held low
// RESET_SEQ | six TMS periods 1,1,1,1,1,0 into Run-Test/Idle
// PRE       | TMS header toward Shift-IR / Shift-DR
// SHIFT     | cmd_len data periods, TMS=1 on the last one
// POST      | TMS 1,0 trailer back to Run-Test/Idle
// RESP      | response presented until rsp_ready
module jtag_master_seq #(
  parameter int DATA_W = 64
) (
  input  logic                   tck,
  input  logic                   trst,
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
  input  logic [7:0]             tck_div,
`endif
  jtag_master_seq_if.slave       bus,
  output logic                   jtag_tck,
  output logic                   jtag_tms,
  output logic                   jtag_tdi,
  input  logic                   jtag_tdo,
  output logic                   busy
);
  localparam int LEN_W = $clog2(DATA_W) + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [1:0] CMD_TAP_RESET = 2'd0;
  localparam logic [1:0] CMD_IR_SCAN   = 2'd1;

  typedef enum logic [2:0] {IDLE, RESET_SEQ, PRE, SHIFT, POST, RESP} state_t;

  state_t            state, nxt_state;
  logic [LEN_W-1:0]  cnt, nxt_cnt, len_q;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] tdi_sr, rsp_data_q;
  logic [IDX_W-1:0]  bit_idx;
  logic              tap_known, cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic              accept, cmd_err, phase_end, seq_done;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept  = bus.cmd_valid && cmd_ready_q;
  assign cmd_err = (bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(DATA_W)) || (bus.cmd_type == 2'd3);

`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
  logic [7:0] div_q, div_cnt;
  assign phase_end = (div_cnt == 8'd0);
`else
  assign phase_end = 1'b1;
`endif

  // cnt counts down the periods left in the current segment; this picks the period that follows
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    seq_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_err) begin
          nxt_state = RESP;
        end else if (bus.cmd_type == CMD_TAP_RESET || !tap_known) begin
          nxt_state = RESET_SEQ;
          nxt_cnt   = LEN_W'(5);
        end else begin
          nxt_state = PRE;
          nxt_cnt   = (bus.cmd_type == CMD_IR_SCAN) ? LEN_W'(3) : LEN_W'(2);
        end
      end
      RESET_SEQ: begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else if (type_q == CMD_TAP_RESET) seq_done = 1'b1;
        else begin
          nxt_state = PRE;
          nxt_cnt   = (type_q == CMD_IR_SCAN) ? LEN_W'(3) : LEN_W'(2);
        end
      end
      PRE: begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else begin
          nxt_state = SHIFT;
          nxt_cnt   = len_q - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else begin
          nxt_state = POST;
          nxt_cnt   = LEN_W'(1);
        end
      end
      POST: begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else seq_done = 1'b1;
      end
      default: ;
    endcase
    if (seq_done) nxt_state = RESP;
  end

  function automatic logic tms_of(state_t s, logic [LEN_W-1:0] c);
    case (s)
      RESET_SEQ: return c != '0;
      PRE:       return c >= LEN_W'(2);
      SHIFT:     return c == '0;
      POST:      return c != '0;
      default:   return 1'b0;
    endcase
  endfunction

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state       <= IDLE;
      cnt         <= '0;
      len_q       <= '0;
      type_q      <= '0;
      tdi_sr      <= '0;
      bit_idx     <= '0;
      tap_known   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
      jtag_tck    <= 1'b0;
      jtag_tms    <= 1'b1;
      jtag_tdi    <= 1'b0;
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
      div_q       <= '0;
      div_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            type_q      <= bus.cmd_type;
            len_q       <= bus.cmd_len;
            tdi_sr      <= bus.cmd_data;
            bit_idx     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= cmd_err;
            cmd_ready_q <= 1'b0;
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
            div_q       <= tck_div;
            div_cnt     <= tck_div;
`endif
            if (cmd_err) begin
              rsp_valid_q <= 1'b1;
            end else begin
              busy     <= 1'b1;
              jtag_tms <= tms_of(nxt_state, nxt_cnt);
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          if (phase_end) begin
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
            div_cnt <= div_q;
`endif
            if (!jtag_tck) begin
              jtag_tck <= 1'b1;
              if (state == SHIFT) begin
                rsp_data_q[bit_idx] <= jtag_tdo;
                bit_idx             <= bit_idx + 1'b1;
              end
            end else begin
              jtag_tck <= 1'b0;
              state    <= nxt_state;
              cnt      <= nxt_cnt;
              if (state == RESET_SEQ && cnt == '0) tap_known <= 1'b1;
              if (nxt_state == RESP) begin
                rsp_valid_q <= 1'b1;
                busy        <= 1'b0;
                jtag_tdi    <= 1'b0;
              end else begin
                jtag_tms <= tms_of(nxt_state, nxt_cnt);
                if (nxt_state == SHIFT) begin
                  jtag_tdi <= tdi_sr[0];
                  tdi_sr   <= tdi_sr >> 1;
                end else begin
                  jtag_tdi <= 1'b0;
                end
              end
            end
          end
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
          else begin
            div_cnt <= div_cnt - 1'b1;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_master_seq.sv
// Directed bench for jtag_master_seq against a small behavioural TAP (4-bit IR, IDCODE 0x0000010F, bypass otherwise).
module tb_jtag_master_seq;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 7;
  localparam logic [1:0] T_RST = 2'd0, T_IR = 2'd1, T_DR = 2'd2;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_010F;
  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [3:0]  IR_CAPTURE = 4'b0101;

  logic tck = 1'b0;
  logic trst = 1'b0;
  logic jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, busy;
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
  logic [7:0] tck_div = 8'd0;
`endif

  jtag_master_seq_if #(.DATA_W(DATA_W)) bus ();

  jtag_master_seq #(.DATA_W(DATA_W)) dut (
    .tck      (tck),
    .trst     (trst),
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
    .tck_div  (tck_div),
`endif
    .bus      (bus.slave),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (jtag_tdo),
    .busy     (busy)
  );

  always #5 tck = ~tck;

  int vectors = 0;
  int miscompares = 0;

  // behavioural target TAP
  int          tap_st = TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        tap_tdo = 1'b0;
  assign jtag_tdo = tap_tdo;

  function automatic int tap_next(int s, logic t);
    case (s)
      TLR:   return t ? TLR   : RTI;
      RTI:   return t ? SELDR : RTI;
      SELDR: return t ? SELIR : CAPDR;
      CAPDR: return t ? EX1DR : SHDR;
      SHDR:  return t ? EX1DR : SHDR;
      EX1DR: return t ? UPDR  : PADR;
      PADR:  return t ? EX2DR : PADR;
      EX2DR: return t ? UPDR  : SHDR;
      UPDR:  return t ? SELDR : RTI;
      SELIR: return t ? TLR   : CAPIR;
      CAPIR: return t ? EX1IR : SHIR;
      SHIR:  return t ? EX1IR : SHIR;
      EX1IR: return t ? UPIR  : PAIR;
      PAIR:  return t ? EX2IR : PAIR;
      EX2IR: return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    case (tap_st)
      TLR:   ir <= IR_IDCODE;
      CAPIR: ir_sr <= IR_CAPTURE;
      SHIR:  ir_sr <= {jtag_tdi, ir_sr[3:1]};
      UPIR:  ir <= ir_sr;
      CAPDR: dr_sr <= (ir == IR_IDCODE) ? IDCODE_VAL : 32'h0;
      SHDR:  dr_sr <= (ir == IR_IDCODE) ? {jtag_tdi, dr_sr[31:1]} : {31'h0, jtag_tdi};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck)
    tap_tdo <= (tap_st == SHDR) ? dr_sr[0] : ((tap_st == SHIR) ? ir_sr[0] : 1'b0);

  // pin monitor: period count, TMS/TDI logs (oldest period in higher bits), high-phase stability
  logic        prev_jtck = 1'b0;
  int          periods = 0;
  int          pin_viol = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;
  logic        tms_hi = 1'b0, tdi_hi = 1'b0;
  always @(negedge tck) begin
    if (jtag_tck === 1'b1 && prev_jtck === 1'b0) begin
      periods++;
      tms_log = {tms_log[62:0], jtag_tms};
      tdi_log = {tdi_log[62:0], jtag_tdi};
      tms_hi  = jtag_tms;
      tdi_hi  = jtag_tdi;
    end else if (jtag_tck === 1'b1 && (jtag_tms !== tms_hi || jtag_tdi !== tdi_hi)) begin
      pin_viol++;
    end
    prev_jtck = jtag_tck;
  end

  task automatic do_cmd(input logic [1:0] t, input logic [LEN_W-1:0] l, input logic [63:0] d, input int hold,
                        output logic [63:0] rd, output logic re, output int cyc, output int per,
                        output logic busy_seen);
    int base, k, w, bad;
    busy_seen = 1'b0;
    @(negedge tck);
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge tck);
      w++;
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    base = periods;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_len   = l;
    bus.cmd_data  = d;
    @(posedge tck);
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 20000) begin
      busy_seen |= (busy === 1'b1);
      @(negedge tck);
      k++;
    end
    per = periods - base;
    cyc = k;
    rd  = bus.rsp_data;
    re  = bus.rsp_err;
    vectors++;
    if (bus.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_valid_wait: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, k);
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge tck);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rd || bus.rsp_err !== re || bus.cmd_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL backpressure_hold: %0d unstable cycles of %0d, required 0", bad, hold);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge tck);
    @(negedge tck);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 trst = 1'b1;
    repeat (3) @(negedge tck);
    vectors++;
    if ({jtag_tck, jtag_tms, jtag_tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL reset_outputs: tck/tms/tdi/rdy/vld/err/busy=%b, required 0100000",
               {jtag_tck, jtag_tms, jtag_tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy});
    end
    vectors++;
    if (bus.rsp_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_rsp_data: rsp_data=%h, required 0", bus.rsp_data);
    end
    trst = 1'b0;
    @(negedge tck);
    vectors++;
    if (bus.cmd_ready !== 1'b1 || jtag_tms !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b tms=%b, required 1 1", bus.cmd_ready, jtag_tms);
    end
  endtask

  task automatic test_dr_autoreset();
    logic [63:0] rd; logic re, bs; int cyc, per;
    do_cmd(T_DR, 7'd32, 64'h0, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h0000_010F || re !== 1'b0) begin
      miscompares++;
      $display("FAIL autoreset_idcode: data=%h err=%b, required 000000000000010f 0", rd, re);
    end
    vectors++;
    if (per != 43 || cyc != 86) begin
      miscompares++;
      $display("FAIL autoreset_periods: periods=%0d cycles=%0d, required 43 86", per, cyc);
    end
    vectors++;
    if (tms_log[42:37] !== 6'b111110 || bs !== 1'b1) begin
      miscompares++;
      $display("FAIL autoreset_tms: tms head=%b busy_seen=%b, required 111110 1", tms_log[42:37], bs);
    end
    vectors++;
    if (tap_st != RTI || jtag_tms !== 1'b0) begin
      miscompares++;
      $display("FAIL autoreset_idle: tap_state=%0d idle_tms=%b, required 1 0", tap_st, jtag_tms);
    end
  endtask

  task automatic test_ir_scan();
    logic [63:0] rd; logic re, bs; int cyc, per;
    do_cmd(T_IR, 7'd4, 64'hA, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h5 || re !== 1'b0) begin
      miscompares++;
      $display("FAIL ir_scan_data: data=%h err=%b, required 0000000000000005 0", rd, re);
    end
    vectors++;
    if (per != 10 || cyc != 20) begin
      miscompares++;
      $display("FAIL ir_scan_periods: periods=%0d cycles=%0d, required 10 20", per, cyc);
    end
    vectors++;
    if (tms_log[9:0] !== 10'b1100000110 || tdi_log[9:0] !== 10'b0000010100) begin
      miscompares++;
      $display("FAIL ir_scan_pins: tms=%b tdi=%b, required 1100000110 0000010100", tms_log[9:0], tdi_log[9:0]);
    end
  endtask

  task automatic test_bypass_backpressure();
    logic [63:0] rd; logic re, bs; int cyc, per;
    do_cmd(T_DR, 7'd8, 64'h5A, 20, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'hB4 || re !== 1'b0 || per != 13 || cyc != 26) begin
      miscompares++;
      $display("FAIL bypass_dr: data=%h err=%b periods=%0d cycles=%0d, required 00000000000000b4 0 13 26",
               rd, re, per, cyc);
    end
  endtask

  task automatic test_tap_reset();
    logic [63:0] rd; logic re, bs; int cyc, per;
    do_cmd(T_RST, 7'd1, 64'hFFFF, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h0 || re !== 1'b0 || per != 6 || cyc != 12) begin
      miscompares++;
      $display("FAIL tap_reset: data=%h err=%b periods=%0d cycles=%0d, required 0 0 6 12", rd, re, per, cyc);
    end
    vectors++;
    if (tms_log[5:0] !== 6'b111110 || tap_st != RTI) begin
      miscompares++;
      $display("FAIL tap_reset_tms: tms=%b tap_state=%0d, required 111110 1", tms_log[5:0], tap_st);
    end
  endtask

  task automatic test_full_width();
    logic [63:0] rd; logic re, bs; int cyc, per;
    do_cmd(T_DR, 7'd64, 64'hDEADBEEF_CAFEF00D, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'hCAFEF00D_0000010F || re !== 1'b0 || per != 69) begin
      miscompares++;
      $display("FAIL full_width_dr: data=%h err=%b periods=%0d, required cafef00d0000010f 0 69", rd, re, per);
    end
  endtask

  task automatic test_errors();
    logic [1:0] et [4];
    logic [6:0] el [4];
    logic [63:0] rd; logic re, bs; int cyc, per;
    et = '{T_DR, 2'd3, T_IR, T_DR};
    el = '{7'd0, 7'd8, 7'd65, 7'd127};
    for (int i = 0; i < 4; i++) begin
      do_cmd(et[i], el[i], 64'hFFFF_FFFF, 0, rd, re, cyc, per, bs);
      vectors++;
      if (rd !== 64'h0 || re !== 1'b1 || cyc != 0 || per != 0 || bs !== 1'b0) begin
        miscompares++;
        $display("FAIL error_cmd_%0d: data=%h err=%b cycles=%0d periods=%0d busy=%b, required 0 1 0 0 0",
                 i, rd, re, cyc, per, bs);
      end
    end
    vectors++;
    if (tap_st != RTI || jtag_tms !== 1'b0) begin
      miscompares++;
      $display("FAIL error_no_pins: tap_state=%0d tms=%b, required 1 0", tap_st, jtag_tms);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] rd; logic re, bs; int cyc, per, base, w;
    @(negedge tck);
    base = periods;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = T_DR;
    bus.cmd_len   = 7'd32;
    bus.cmd_data  = 64'h0;
    @(posedge tck);
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    w = 0;
    while ((periods - base) < 10 && w < 500) begin
      @(negedge tck);
      w++;
    end
    trst = 1'b1;
    #1;
    vectors++;
    if ({jtag_tck, jtag_tms, jtag_tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy} !== 7'b0100000 ||
        bus.rsp_data !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: pins=%b data=%h, required 0100000 0",
               {jtag_tck, jtag_tms, jtag_tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy}, bus.rsp_data);
    end
    @(negedge tck);
    trst = 1'b0;
    @(negedge tck);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || jtag_tms !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_release: vld=%b rdy=%b tms=%b, required 0 1 1", bus.rsp_valid, bus.cmd_ready, jtag_tms);
    end
    do_cmd(T_DR, 7'd32, 64'h0, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h0000_010F || per != 43 || tms_log[42:37] !== 6'b111110) begin
      miscompares++;
      $display("FAIL mid_reset_rescan: data=%h periods=%0d tms head=%b, required 000000000000010f 43 111110",
               rd, per, tms_log[42:37]);
    end
  endtask

`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
  task automatic test_div();
    logic [63:0] rd; logic re, bs; int cyc, per;
    tck_div = 8'd3;
    do_cmd(T_IR, 7'd4, 64'hA, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h5 || per != 10 || cyc != 80 || tms_log[9:0] !== 10'b1100000110) begin
      miscompares++;
      $display("FAIL div_ir_scan: data=%h periods=%0d cycles=%0d tms=%b, required 5 10 80 1100000110",
               rd, per, cyc, tms_log[9:0]);
    end
    do_cmd(T_IR, 7'd4, 64'h1, 0, rd, re, cyc, per, bs);
    do_cmd(T_DR, 7'd32, 64'h0, 0, rd, re, cyc, per, bs);
    vectors++;
    if (rd !== 64'h0000_010F || per != 37 || cyc != 296) begin
      miscompares++;
      $display("FAIL div_dr_scan: data=%h periods=%0d cycles=%0d, required 000000000000010f 37 296", rd, per, cyc);
    end
    tck_div = 8'd0;
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_dr_autoreset();
    test_ir_scan();
    test_bypass_backpressure();
    test_tap_reset();
    test_full_width();
    test_errors();
    test_reset_mid_shift();
`ifdef JTAG_MASTER_SEQ_TCK_DIV_EN
    test_div();
`endif
    vectors++;
    if (pin_viol != 0) begin
      miscompares++;
      $display("FAIL pins_stable_high: %0d changes of tms/tdi while jtag_tck high, required 0", pin_viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_master_seq.md
JTAG_MASTER_SEQ -- requirements
Module: jtag_master_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the maximum scan length in bits and the width of the data buses.
REQ-002 The block SHALL have port tck, input, 1 bit: single system clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port trst, input, 1 bit: asynchronous active-high reset (one clock; asynchronous, active-high reset).
REQ-004 The block SHALL have ports cmd_valid (in, 1) and cmd_ready (out, 1): the command handshake.
REQ-005 The block SHALL have port cmd_type, in, 2 bits: 0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=reserved.
REQ-006 The block SHALL have port cmd_len, in, $clog2(DATA_W)+1 bits: number of bits to shift.
REQ-007 The block SHALL have port cmd_data, in, DATA_W bits: TDI bits, sent LSB first.
REQ-008 The block SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, DATA_W) and rsp_err (out, 1): the response handshake, captured TDO bits and error flag.
REQ-009 The block SHALL have ports jtag_tck, jtag_tms and jtag_tdi (out, 1 each) and jtag_tdo (in, 1): the target TAP pins.
REQ-010 The block SHALL have port busy, out, 1 bit: high whenever a sequence is executing.

Function
REQ-011 Each JTAG bit period SHALL consist of a low phase followed by a high phase of jtag_tck; each phase is 1 tck cycle unless the divider is enabled.
REQ-012 jtag_tms and jtag_tdi SHALL change only on the tck edge that drives jtag_tck low; jtag_tdo SHALL be sampled on the tck edge that drives jtag_tck high.
REQ-013 A command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-014 cmd_ready SHALL be high only in IDLE with rsp_valid low.
REQ-015 TAP_RESET SHALL drive TMS 1,1,1,1,1,0 (6 periods) and end in Run-Test/Idle.
REQ-016 IR_SCAN SHALL drive TMS 1,1,0,0 from Run-Test/Idle, then cmd_len shift periods with TMS=0 except the last (TMS=1), then 1,0; total cmd_len+6 periods.
REQ-017 DR_SCAN SHALL drive TMS 1,0,0, then the shift periods as for IR_SCAN, then 1,0; total cmd_len+5 periods.
REQ-018 During shift period i (0-based), jtag_tdi SHALL equal cmd_data[i] and the sampled jtag_tdo SHALL be stored in rsp_data[i]; bits >= cmd_len SHALL read 0; jtag_tdi SHALL be 0 outside shift periods.
REQ-019 An internal tap_known flag SHALL be cleared by reset and set by a completed TAP_RESET; a scan accepted while tap_known=0 SHALL first run the 6-period TAP_RESET sequence automatically.
REQ-020 The FSM SHALL have states IDLE, RESET_SEQ, PRE (TMS header), SHIFT, POST (TMS trailer) and RESP; transitions: IDLE->RESET_SEQ|PRE->SHIFT->POST->RESP->IDLE.
REQ-021 rsp_valid SHALL assert one cycle after the high phase of the final period and hold, with rsp_data and rsp_err stable, until rsp_ready is high.
REQ-022 A command with cmd_len=0, cmd_len>DATA_W or cmd_type=3 SHALL produce no jtag_tck activity and SHALL return rsp_valid the next cycle with rsp_err=1 and rsp_data=0.
REQ-023 TAP_RESET SHALL return rsp_data=0 and rsp_err=0.
REQ-024 In IDLE, jtag_tck SHALL be held at 0 and jtag_tms at 0 (or 1 if tap_known=0).

Reset
REQ-025 While trst is high, all outputs SHALL take these values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0; cmd_ready SHALL rise on the first cycle after release.
REQ-026 Reset asserted mid-sequence SHALL abort immediately, drop any pending response and clear tap_known.

Configuration
REQ-027 With JTAG_MASTER_SEQ_TCK_DIV_EN defined, the block SHALL add input tck_div[7:0], sampled at command accept, and each jtag_tck phase SHALL last tck_div+1 tck cycles.
REQ-028 Without JTAG_MASTER_SEQ_TCK_DIV_EN, the tck_div port SHALL not exist and each phase SHALL last 1 cycle.

Verification
REQ-029 Scenario: after reset, DR_SCAN with len=32 to jtag_wrapper with IDCODE selected -> auto-reset of 6 periods, then rsp_data=0x0000010F, rsp_err=0, total 43 periods.
REQ-030 Scenario: IR_SCAN with len=4 and data=0xA -> TDI bits 0,1,0,1, TMS sequence 1100 0001 10, rsp_valid after 10 periods.
REQ-031 Scenario: cmd_len=0 or cmd_type=3 -> no jtag_tck edges, rsp_err=1 on the next cycle.
REQ-032 Scenario: rsp_ready held low 20 cycles -> rsp_valid and rsp_data stable, and cmd_ready=0 throughout.
REQ-033 Scenario: trst pulsed during SHIFT -> outputs at reset values, and the next DR_SCAN is preceded by the auto-reset sequence.
REQ-034 Scenario: with JTAG_MASTER_SEQ_TCK_DIV_EN and tck_div=3 -> jtag_tck period of 8 cycles, and results identical to the undivided run.
